// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer reader.
// Holds the fetch FSM encoding, Wishbone cycle-type codes and the pixel width.
package fb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  localparam int unsigned PIX_W = 24;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with clock and reset, as seen by a burst master and a slave.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic [31:0] dat_sm;
  logic [31:0] dat_ms;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    input  clk, rst, dat_sm, ack,
    output adr, dat_ms, we, sel, stb, cyc, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/pix_fifo.sv
// Synchronous first-word-fall-through FIFO holding {sof, pixel} entries.
// The head entry is presented combinationally; outputs read as zero while empty.
module pix_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [PIX_W:0]        wdata_i,
  input  logic                  pop_i,
  output logic [PIX_W:0]        rdata_o,
  output logic                  empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PIX_W:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           full;
  logic           do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_i, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty gate on rdata_o hides stale contents.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // The reader only starts a burst when a full burst of space is free.
  push_not_full_a : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full));

endmodule

// File: rtl/fb_reader.sv
// Frame-buffer reader: fetches HDISP*VDISP pixels per frame over Wishbone incrementing
// bursts into a FWFT pixel FIFO, starting a burst only when the FIFO can absorb it whole.
module fb_reader #(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480,
  parameter int unsigned BURST = 64,
  parameter int unsigned DEPTH = 128
) (
  wshb_if.master      wshb_ifm,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int unsigned NPIX = HDISP * VDISP;
  localparam int unsigned IW   = $clog2(NPIX);
  localparam int unsigned BW   = $clog2(BURST) + 1;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  if (DEPTH < 2 * BURST) begin : g_bad_depth
    $error("fb_reader: DEPTH must be at least 2*BURST");
  end
  if ((BURST & (BURST - 1)) != 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_pow2
    $error("fb_reader: BURST and DEPTH must be powers of two");
  end

  logic clk;
  logic rst;

  fb_pkg::state_e state_q, state_d;
  logic [IW-1:0]  pix_idx_q, pix_idx_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [BW-1:0]  blen_q, blen_d;
  logic           stb_q, stb_d;
  logic [2:0]     cti_q, cti_d;

  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  free_cnt;
  logic [31:0]    remain;
  logic [31:0]    first_len;
  logic [31:0]    idx32;
  logic           last_beat;
  logic           push;
  logic           fifo_empty;
  logic [fb_pkg::PIX_W:0] fifo_wdata;
  logic [fb_pkg::PIX_W:0] fifo_rdata;
  logic           unused_dat;

  assign clk = wshb_ifm.clk;
  assign rst = wshb_ifm.rst;

  assign free_cnt  = CW'(DEPTH) - fifo_count;
  // Bursts are clipped so they never run past the last pixel of the frame.
  assign remain    = NPIX - 32'(pix_idx_q);
  assign first_len = (remain >= BURST) ? BURST : remain;
  assign last_beat = (beat_q == blen_q - BW'(1));
  assign push      = stb_q && wshb_ifm.ack && (state_q == fb_pkg::BURST);

  assign fifo_wdata = {(pix_idx_q == '0), wshb_ifm.dat_sm[fb_pkg::PIX_W-1:0]};
  assign unused_dat = ^wshb_ifm.dat_sm[31:fb_pkg::PIX_W];

  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    beat_d    = beat_q;
    blen_d    = blen_q;
    stb_d     = stb_q;
    cti_d     = cti_q;
    unique case (state_q)
      fb_pkg::IDLE: begin
        stb_d = 1'b0;
        cti_d = '0;
        if (free_cnt >= CW'(BURST)) begin
          state_d = fb_pkg::BURST;
          stb_d   = 1'b1;
          beat_d  = '0;
          blen_d  = BW'(first_len);
          cti_d   = (first_len == 32'd1) ? fb_pkg::CTI_EOB : fb_pkg::CTI_INCR;
        end
      end
      fb_pkg::BURST: begin
        if (push) begin
          pix_idx_d = (pix_idx_q == IW'(NPIX - 1)) ? '0 : pix_idx_q + IW'(1);
          beat_d    = beat_q + BW'(1);
          if (last_beat) begin
            state_d = fb_pkg::IDLE;
            stb_d   = 1'b0;
            cti_d   = '0;
          end else begin
            cti_d = (beat_q + BW'(2) == blen_q) ? fb_pkg::CTI_EOB : fb_pkg::CTI_INCR;
          end
        end
      end
      default: begin
        state_d = fb_pkg::IDLE;
        stb_d   = 1'b0;
        cti_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= fb_pkg::IDLE;
      pix_idx_q <= '0;
      beat_q    <= '0;
      blen_q    <= '0;
      stb_q     <= 1'b0;
      cti_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      beat_q    <= beat_d;
      blen_q    <= blen_d;
      stb_q     <= stb_d;
      cti_q     <= cti_d;
    end
  end

  assign idx32           = 32'(pix_idx_q);
  assign wshb_ifm.adr    = {idx32[29:0], 2'b00};
  assign wshb_ifm.stb    = stb_q;
  assign wshb_ifm.cyc    = stb_q;
  assign wshb_ifm.cti    = cti_q;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.dat_ms = '0;

  pix_fifo #(
    .DEPTH (DEPTH)
  ) u_pix_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pix_ready),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_rdata[fb_pkg::PIX_W-1:0];
  assign pix_sof   = fifo_rdata[fb_pkg::PIX_W];

endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 Parameter HDISP, default 800, pixels per line.
REQ-002 Parameter VDISP, default 480, lines per frame.
REQ-003 Parameter BURST, default 64, maximum beats per Wishbone burst; power of two.
REQ-004 Parameter DEPTH, default 128, pixel FIFO depth; power of two, >= 2*BURST.
REQ-005 wshb_ifm.clk  input  1  single clock; all logic on rising edge.
REQ-006 wshb_ifm.rst  input  1  reset, asynchronous, active-high.
REQ-007 wshb_ifm  modport master  -  Wishbone bus (adr 32, dat_sm 32 in, dat_ms 32 out, we, sel 4, stb, cyc, cti 3, bte 2, ack in).
REQ-008 pix_data  output  24  RGB pixel, dat_sm[23:0] of the acked beat.
REQ-009 pix_sof  output  1  high with the pixel at frame index 0.
REQ-010 pix_valid  output  1  pix_data/pix_sof valid.
REQ-011 pix_ready  input  1  consumer accepts the pixel when pix_valid && pix_ready.

Function
REQ-012 Constant bus outputs: we=0, sel=4'b1111, bte=0, dat_ms=0, cyc=stb.
REQ-013 FSM states IDLE, BURST; reset state IDLE.
REQ-014 IDLE: stb=0; go to BURST when free = DEPTH - fifo_count >= BURST.
REQ-015 BURST: stb=1; each ack pushes one pixel, adr += 4, beat and frame counters += 1.
REQ-016 Burst length = min(BURST, HDISP*VDISP - pixel_index); burst never crosses frame end.
REQ-017 cti=3'b010 on all beats except the last beat of a burst, cti=3'b111.
REQ-018 On last-beat ack: return to IDLE (stb low >= 1 cycle between bursts).
REQ-019 On ack of pixel index HDISP*VDISP-1: adr and pixel index wrap to 0 on the next cycle.
REQ-020 adr = 4*pixel_index at all times; byte address, bits [1:0]=0.
REQ-021 stb without ack: hold adr, cti, beat counter unchanged (wait states allowed).
REQ-022 FIFO first-word-fall-through: pix_valid = !empty, pix_data/pix_sof = head entry.
REQ-023 FIFO entry = {sof, data[23:0]}; sof=1 iff pushed beat's pixel index is 0.
REQ-024 Simultaneous push and pop: count unchanged, both take effect same cycle.
REQ-025 Pop on empty ignored; push on full impossible by REQ-014 (assertion required).
REQ-026 Latency: ack at cycle n -> pixel visible on pix_* at n+1 when FIFO was empty.
REQ-027 Counter widths: pixel index $clog2(HDISP*VDISP) bits, FIFO count $clog2(DEPTH)+1 bits.

Reset
REQ-028 During reset: stb=0, cti=0, adr=0, pixel index 0, FSM IDLE, FIFO empty, pix_valid=0, pix_data=0, pix_sof=0.
REQ-029 Reset asserted mid-burst drops stb immediately (asynchronous); no ack pushed during reset.
REQ-030 After reset release, first burst starts at adr 0 with pix_sof on the first pixel.

Structure
REQ-031 Package fb_pkg holds: state enum (IDLE, BURST), CTI_INCR=3'b010, CTI_EOB=3'b111, PIX_W=24.
REQ-032 FIFO is sub-module pix_fifo (sync, FWFT, DEPTH x 25 bits, count output).
REQ-033 fb_reader holds FSM, address/pixel counters, burst counter, credit check.

Verification
REQ-034 Reset, slave acks every cycle, pix_ready=1 -> bursts of 64 at adr 0,4,...; first pixel pix_sof=1; stb low 1 cycle between bursts.
REQ-035 pix_ready=0 from reset -> exactly two bursts (128 pixels) fetched, then stb stays 0; raise pix_ready -> fetching resumes once 64 pop.
REQ-036 HDISP=10, VDISP=10, BURST=64 -> bursts of 64 then 36 (cti=111 on beat 36), next burst adr 0 with pix_sof=1.
REQ-037 Slave inserts random wait states (ack ~50%) -> pixel stream equals memory contents in address order, no loss/duplication.
REQ-038 Assert rst at beat 20 of a burst -> stb=0 same cycle, FIFO empty, restart at adr 0 after release.
REQ-039 Pattern memory word = address/4 -> pix_data sequence 0,1,2,... modulo HDISP*VDISP across 3 frames.
